ifu_fetch_queue: RTL and testbench
==================================

Name: ifu_fetch_queue

Overview:
- Instruction-fetch front end and the producer side of the branch unit's interface.
- Holds the fetch PC and issues paired-word reads to instruction memory. Buffers returned instruction pairs in a small FIFO.
- Presents p0/p1 instruction words to the branch unit and decode, and accepts PC redirects from the branch unit.
- Tags the first pair after an odd-address redirect so that p0 is marked invalid.

Parameters:
- DEPTH, 4, number of instruction-pair entries in the FIFO (power of 2, 2..8).
- MAX_OUT, 2, maximum outstanding memory requests (1..3).
- RESET_PC, 9'h000, fetch PC after reset (must be even).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- imem_req  output  1  read request valid.
- imem_addr  output  8  pair address (PC[8:1]).
- imem_gnt  input  1  request accepted this cycle when imem_req=1.
- imem_rvalid  input  1  read data valid; responses return in request order, latency ≥1.
- imem_rdata  input  32  [15:0] = even-address instruction (p0), [31:16] = odd-address instruction (p1).
- redirect_valid  input  1  branch taken; flush and refetch.
- redirect_pc  input  9  branch destination (may be odd).
- fetch_next_in  input  1  consumer pops the head pair.
- out_valid  output  1  head pair present.
- out_pc  output  9  even PC of the head pair.
- p0_IR_out  output  16  head p0 instruction.
- p1_IR_out  output  16  head p1 instruction.
- IR0_invalid_out  output  1  head p0 must not execute.

Behaviour:
- Reset (rst=0 at a clock edge):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; odd_pending=0; state=RUN.
  - All outputs 0.
- Request issue:
  - imem_req=1 when state=RUN and outstanding+count < DEPTH and outstanding < MAX_OUT.
  - imem_addr=fetch_pc[8:1].
  - On gnt, fetch_pc += 2. The 9-bit PC wraps 0x1FE to 0x000.
  - The request is combinational from registers only; imem_req does not depend on imem_gnt.
- Response:
  - If discard>0, the response is dropped and discard decrements.
  - Otherwise the pair is pushed with pc and inv flag. The pair's pc comes from an internal in-order tag FIFO of depth MAX_OUT. inv is the odd_pending value captured at grant time.
  - odd_pending clears on the first grant after it was set.
  - Space is reserved at issue, so a push never finds the FIFO full.
- Output:
  - The head is registered FIFO storage. out_valid = count>0.
  - A pop happens when fetch_next_in=1 and out_valid=1. fetch_next_in while empty is ignored.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Latency: a response at cycle N is visible at the head at N+1 if the FIFO was empty.
- Redirect (redirect_valid=1 at cycle N):
  - At the edge: FIFO flushed, fetch_pc={redirect_pc[8:1],0}, odd_pending=redirect_pc[0].
  - discard = outstanding after counting this cycle's gnt and rvalid. A grant in cycle N is therefore stale, and rvalid in cycle N is dropped.
  - A pop in cycle N is ignored.
  - If discard>0 the state goes to DRAIN; otherwise it stays in RUN.
  - The first new request issues at N+1 in RUN, or once discard reaches 0 in DRAIN.
- State machine:
  - RUN: normal operation. Goes to DRAIN on a redirect with stale requests.
  - DRAIN: imem_req=0. Returns to RUN in the cycle discard decrements to 0. A further redirect in DRAIN reloads fetch_pc and odd_pending; discard stays consistent with outstanding.
- Invariants:
  - outstanding ≤ MAX_OUT.
  - count+outstanding ≤ DEPTH.
  - discard ≤ outstanding.
- Reset mid-operation: all state cleared. Later rvalid pulses from pre-reset requests are the memory's responsibility; imem is reset together with this block.

Decomposition:
- Shared package ifu_pkg:
  - PC_W=9; IR_W=16.
  - typedef fetch_pair_t {pc[8:0], p0[15:0], p1[15:0], inv}.
  - typedef fq_state_e {RUN, DRAIN}.
- Sub-module fq_fifo: a generic synchronous FIFO of fetch_pair_t with flush, push, pop and count.
- The top level holds the PC, request control, tag FIFO and discard counter.

Test Plan:
- Reset then free-run, memory latency 1, consumer always ready -> imem_addr sequence 0x00,0x01,0x02…; out_pc 0x000,0x002,0x004; IR0_invalid_out=0.
- Consumer stalls (fetch_next_in=0) for 10 cycles -> FIFO fills to 4; imem_req drops with count+outstanding=4; no data is lost when popping resumes.
- Redirect to 0x011 while 2 requests are outstanding (latency 3) -> the 2 stale responses are dropped; the next head has out_pc=0x010 and IR0_invalid_out=1; the following pair has out_pc=0x012 and IR0_invalid_out=0.
- Redirect in the same cycle as a gnt, an rvalid and a pop -> the grant is counted as stale, the rvalid is dropped and the pop is ignored; out_valid=0 next cycle.
- Fetch near the top of memory from PC 0x1FC -> out_pc 0x1FC, 0x1FE, 0x000 (wrap).
- rst=0 asserted during DRAIN -> next cycle all outputs are 0 and fetch_pc=RESET_PC; fetching restarts in RUN.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifu_pkg;

    localparam int PC_W = 9;
    localparam int IR_W = 16;

    // One fetched instruction pair plus its even PC and the "p0 is dead" tag.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [IR_W-1:0] p0;
        logic [IR_W-1:0] p1;
        logic            inv;
    } fetch_pair_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fq_state_e;

    // Advance a pair-aligned PC; the 9-bit PC wraps naturally at the top.
    function automatic logic [PC_W-1:0] next_pair_pc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(2);
    endfunction

endpackage

// File: rtl/ifu_fetch_queue_fifo.sv
// Synchronous FIFO of fetch pairs with flush. Head is read straight from
// registered storage; the consumer qualifies it with count.
module fq_fifo
    import ifu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_pair_t   push_data,
    input  logic          pop,
    output fetch_pair_t   head,
    output logic [CW-1:0] count
);

    fetch_pair_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointer and occupancy tracking; flush empties the queue in one edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Data storage; no reset needed since nothing reads an empty slot.
    always_ff @(posedge clk) begin
        if (rst && !flush && push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues pair reads with a
// bounded number in flight, buffers returned pairs and handles redirects by
// discarding responses to requests that were in flight at the redirect.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [PC_W-1:0] RESET_PC = 9'h000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [7:0]      imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            fetch_next_in,
    output logic            out_valid,
    output logic [PC_W-1:0] out_pc,
    output logic [IR_W-1:0] p0_IR_out,
    output logic [IR_W-1:0] p1_IR_out,
    output logic            IR0_invalid_out
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    fq_state_e       state, state_nxt;
    logic            live;
    logic [PC_W-1:0] fetch_pc;
    logic            odd_pending;
    logic [OW-1:0]   outstanding, outst_nxt;
    logic [OW-1:0]   discard, discard_nxt;
    logic [CW-1:0]   count;

    logic [PC_W-1:0] tag_pc  [MAX_OUT];
    logic            tag_inv [MAX_OUT];
    logic [TW-1:0]   tag_wr;
    logic [TW-1:0]   tag_rd;

    logic            gnt_fire;
    logic            rsp;
    logic            push;
    logic            pop;
    fetch_pair_t     push_data;
    fetch_pair_t     head;

    // Request depends on registers only; space for the response is reserved
    // at issue so a push can never overflow the FIFO. live holds requests off
    // for the first cycle after reset so every output reads zero there.
    assign imem_req  = live && (state == RUN) &&
                       (int'(outstanding) + int'(count) < DEPTH) &&
                       (int'(outstanding) < MAX_OUT);
    assign imem_addr = fetch_pc[PC_W-1:1];
    assign gnt_fire  = imem_req && imem_gnt;

    // A stray rvalid with nothing in flight is ignored rather than underflowing.
    assign rsp  = imem_rvalid && (outstanding != '0);
    assign push = rsp && (discard == '0) && !redirect_valid;
    assign pop  = fetch_next_in && out_valid && !redirect_valid;

    assign push_data.pc  = tag_pc[tag_rd];
    assign push_data.p0  = imem_rdata[15:0];
    assign push_data.p1  = imem_rdata[31:16];
    assign push_data.inv = tag_inv[tag_rd];

    // In-flight count after this cycle's grant and response.
    always_comb begin
        outst_nxt = outstanding;
        case ({gnt_fire, rsp})
            2'b10:   outst_nxt = outstanding + OW'(1);
            2'b01:   outst_nxt = outstanding - OW'(1);
            default: outst_nxt = outstanding;
        endcase
    end

    // Next state and discard count; a redirect marks everything still in
    // flight (including this cycle's grant) as stale.
    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        if (rsp && (discard != '0)) discard_nxt = discard - OW'(1);
        case (state)
            RUN:     state_nxt = RUN;
            DRAIN:   if (discard_nxt == '0) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
        if (redirect_valid) begin
            discard_nxt = outst_nxt;
            state_nxt   = (outst_nxt != '0) ? DRAIN : RUN;
        end
    end

    // Control registers: state, PC, odd-redirect tag, counters, tag pointers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            live        <= 1'b0;
            fetch_pc    <= RESET_PC;
            odd_pending <= 1'b0;
            outstanding <= '0;
            discard     <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
        end else begin
            state       <= state_nxt;
            live        <= 1'b1;
            outstanding <= outst_nxt;
            discard     <= discard_nxt;
            if (redirect_valid) begin
                fetch_pc    <= {redirect_pc[PC_W-1:1], 1'b0};
                odd_pending <= redirect_pc[0];
            end else if (gnt_fire) begin
                fetch_pc    <= next_pair_pc(fetch_pc);
                odd_pending <= 1'b0;
            end
            if (gnt_fire)
                tag_wr <= (tag_wr == TW'(MAX_OUT - 1)) ? '0 : tag_wr + TW'(1);
            if (rsp)
                tag_rd <= (tag_rd == TW'(MAX_OUT - 1)) ? '0 : tag_rd + TW'(1);
        end
    end

    // Tag FIFO payload: PC and odd flag of each granted request, in order.
    // Stale grants still get a tag so the response lines up when it returns.
    always_ff @(posedge clk) begin
        if (rst && gnt_fire) begin
            tag_pc[tag_wr]  <= fetch_pc;
            tag_inv[tag_wr] <= odd_pending;
        end
    end

    fq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign out_valid       = (count != '0);
    assign out_pc          = out_valid ? head.pc  : '0;
    assign p0_IR_out       = out_valid ? head.p0  : '0;
    assign p1_IR_out       = out_valid ? head.p1  : '0;
    assign IR0_invalid_out = out_valid && head.inv;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue with an in-order memory model of
// configurable latency. Memory data encodes the pair PC so heads are traceable.
module tb_ifu_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [8:0]  redirect_pc;
    logic        fetch_next_in;
    logic        out_valid;
    logic [8:0]  out_pc;
    logic [15:0] p0_IR_out;
    logic [15:0] p1_IR_out;
    logic        IR0_invalid_out;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int lat    = 1;
    logic [7:0] q_addr[$];
    int         q_due[$];

    ifu_fetch_queue dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .fetch_next_in   (fetch_next_in),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .p0_IR_out       (p0_IR_out),
        .p1_IR_out       (p1_IR_out),
        .IR0_invalid_out (IR0_invalid_out)
    );

    always #5 clk = ~clk;

    // One clock: record this cycle's grant, take the edge, then present the
    // memory response due in the new cycle. Returns at the falling edge.
    task automatic tick();
        logic [8:0] rp;
        if (imem_req && imem_gnt) begin
            q_addr.push_back(imem_addr);
            q_due.push_back(cyc + lat);
        end
        @(posedge clk);
        if (!rst) begin
            q_addr.delete();
            q_due.delete();
        end
        @(negedge clk);
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            void'(q_due.pop_front());
            rp          = {q_addr.pop_front(), 1'b0};
            imem_rvalid = 1'b1;
            imem_rdata  = {16'h2000 | {7'd0, rp | 9'd1}, 16'h1000 | {7'd0, rp}};
        end
    endtask

    // Pulse reset for one edge; returns in the first cycle that may request.
    task automatic do_reset();
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        fetch_next_in = 1'b0; imem_gnt = 1'b1;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; fetch_next_in = 1'b0;
        tick(); tick();
        total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", imem_req); else passed++;
        total++; if (imem_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", imem_addr); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid); else passed++;
        total++; if ({out_pc, p0_IR_out, p1_IR_out, IR0_invalid_out} !== '0)
            $display("FAIL reset_data: got %h/%h/%h/%0b want zeros", out_pc, p0_IR_out, p1_IR_out, IR0_invalid_out);
        else passed++;
    endtask

    task automatic test_free_run();
        lat = 1;
        do_reset();
        fetch_next_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++; if (imem_req !== 1'b1 || imem_addr !== 8'(i))
                $display("FAIL free_addr[%0d]: got req=%0b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, 8'(i));
            else passed++;
            if (i >= 2) begin
                total++; if (out_valid !== 1'b1 || out_pc !== 9'(2*(i-2)) || IR0_invalid_out !== 1'b0)
                    $display("FAIL free_head[%0d]: got v=%0b pc=%h inv=%0b want v=1 pc=%h inv=0", i, out_valid, out_pc, IR0_invalid_out, 9'(2*(i-2)));
                else passed++;
                total++; if (p0_IR_out !== (16'h1000 | 16'(2*(i-2))))
                    $display("FAIL free_p0[%0d]: got %h want %h", i, p0_IR_out, 16'h1000 | 16'(2*(i-2)));
                else passed++;
            end
            tick();
        end
    endtask

    // Continues from test_free_run: head pc 0x008 is on display now.
    task automatic test_stall();
        fetch_next_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total++; if (imem_req !== 1'b0) $display("FAIL stall_req: got %0b want 0", imem_req); else passed++;
        total++; if (out_valid !== 1'b1 || out_pc !== 9'h008)
            $display("FAIL stall_head: got v=%0b pc=%h want v=1 pc=008", out_valid, out_pc);
        else passed++;
        fetch_next_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            total++; if (out_valid !== 1'b1 || out_pc !== 9'(8 + 2*k) || p1_IR_out !== (16'h2000 | 16'(9 + 2*k)))
                $display("FAIL stall_drain[%0d]: got v=%0b pc=%h p1=%h want v=1 pc=%h p1=%h", k, out_valid, out_pc, p1_IR_out, 9'(8 + 2*k), 16'h2000 | 16'(9 + 2*k));
            else passed++;
            tick();
        end
    endtask

    task automatic test_redirect_odd();
        lat = 3;
        do_reset();
        fetch_next_in = 1'b1;
        tick(); tick();
        total++; if (imem_req !== 1'b0) $display("FAIL rdo_maxout: got req=%0b want 0", imem_req); else passed++;
        redirect_valid = 1'b1; redirect_pc = 9'h011;
        tick();
        redirect_valid = 1'b0;
        total++; if (imem_req !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL rdo_drain1: got req=%0b v=%0b want 0 0", imem_req, out_valid);
        else passed++;
        tick();
        total++; if (imem_req !== 1'b0) $display("FAIL rdo_drain2: got req=%0b want 0", imem_req); else passed++;
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 8'h08 || out_valid !== 1'b0)
            $display("FAIL rdo_refetch: got req=%0b addr=%h v=%0b want 1 08 0", imem_req, imem_addr, out_valid);
        else passed++;
        tick(); tick(); tick();
        total++; if (out_valid !== 1'b0) $display("FAIL rdo_nostale: got v=%0b want 0", out_valid); else passed++;
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 9'h010 || IR0_invalid_out !== 1'b1 || p0_IR_out !== 16'h1010)
            $display("FAIL rdo_first: got v=%0b pc=%h inv=%0b p0=%h want 1 010 1 1010", out_valid, out_pc, IR0_invalid_out, p0_IR_out);
        else passed++;
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 9'h012 || IR0_invalid_out !== 1'b0)
            $display("FAIL rdo_second: got v=%0b pc=%h inv=%0b want 1 012 0", out_valid, out_pc, IR0_invalid_out);
        else passed++;
    endtask

    task automatic test_redirect_same_cycle();
        lat = 1;
        do_reset();
        fetch_next_in = 1'b1;
        tick(); tick();
        total++; if (out_valid !== 1'b1 || imem_req !== 1'b1 || imem_rvalid !== 1'b1)
            $display("FAIL rsc_setup: got v=%0b req=%0b rvalid=%0b want 1 1 1", out_valid, imem_req, imem_rvalid);
        else passed++;
        redirect_valid = 1'b1; redirect_pc = 9'h040;
        tick();
        redirect_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL rsc_flush: got v=%0b req=%0b want 0 0", out_valid, imem_req);
        else passed++;
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 8'h20)
            $display("FAIL rsc_refetch: got req=%0b addr=%h want 1 20", imem_req, imem_addr);
        else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL rsc_dropped: got v=%0b want 0", out_valid); else passed++;
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 9'h040 || IR0_invalid_out !== 1'b0)
            $display("FAIL rsc_head: got v=%0b pc=%h inv=%0b want 1 040 0", out_valid, out_pc, IR0_invalid_out);
        else passed++;
    endtask

    task automatic test_wrap();
        lat = 1;
        do_reset();
        fetch_next_in = 1'b1;
        imem_gnt = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 9'h1FC;
        tick();
        redirect_valid = 1'b0; imem_gnt = 1'b1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 8'hFE)
            $display("FAIL wrap_start: got req=%0b addr=%h want 1 fe", imem_req, imem_addr);
        else passed++;
        tick();
        total++; if (imem_addr !== 8'hFF) $display("FAIL wrap_addr1: got %h want ff", imem_addr); else passed++;
        tick();
        total++; if (out_pc !== 9'h1FC || imem_addr !== 8'h00)
            $display("FAIL wrap_a: got pc=%h addr=%h want 1fc 00", out_pc, imem_addr);
        else passed++;
        tick();
        total++; if (out_pc !== 9'h1FE) $display("FAIL wrap_b: got pc=%h want 1fe", out_pc); else passed++;
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 9'h000 || p0_IR_out !== 16'h1000)
            $display("FAIL wrap_c: got v=%0b pc=%h p0=%h want 1 000 1000", out_valid, out_pc, p0_IR_out);
        else passed++;
    endtask

    task automatic test_reset_in_drain();
        lat = 3;
        do_reset();
        fetch_next_in = 1'b1;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 9'h080;
        tick();
        redirect_valid = 1'b0;
        total++; if (imem_req !== 1'b0 || imem_addr !== 8'h40)
            $display("FAIL rid_drain: got req=%0b addr=%h want 0 40", imem_req, imem_addr);
        else passed++;
        rst = 1'b0;
        tick();
        total++; if ({imem_req, imem_addr, out_valid, out_pc, p0_IR_out, p1_IR_out, IR0_invalid_out} !== '0)
            $display("FAIL rid_zero: got req=%0b addr=%h v=%0b pc=%h p0=%h p1=%h inv=%0b want zeros",
                     imem_req, imem_addr, out_valid, out_pc, p0_IR_out, p1_IR_out, IR0_invalid_out);
        else passed++;
        rst = 1'b1;
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 8'h00)
            $display("FAIL rid_restart: got req=%0b addr=%h want 1 00", imem_req, imem_addr);
        else passed++;
        tick(); tick(); tick(); tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 9'h000 || IR0_invalid_out !== 1'b0)
            $display("FAIL rid_head: got v=%0b pc=%h inv=%0b want 1 000 0", out_valid, out_pc, IR0_invalid_out);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_odd();
        test_redirect_same_cycle();
        test_wrap();
        test_reset_in_drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
